// File: rtl/gate_test_sequencer.sv
// Self-checking sequencer for the NOT/NAND gate cells: sweeps the four input vectors,
// samples the gate outputs after a settle time and accumulates a saturating error count.
module gate_test_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             start,
   input  logic             abort,
   input  logic             out_not,
   input  logic             out_nand,
   output logic             in_not,
   output logic             in1_nand,
   output logic             in2_nand,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [PC_W-1:0] PASS_LAST   = PC_W'(PASSES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
   logic [SC_W-1:0]  settle_q, settle_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [3:0]       fail_vec_q, fail_vec_d;
   logic             pass_q, pass_d;
   logic             in_not_q, in_not_d;
   logic             in1_q, in1_d;
   logic             in2_q, in2_d;
   logic             exp_not, exp_nand, mismatch;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pass_cnt_d  = pass_cnt_q;
      settle_d    = settle_q;
      err_count_d = err_count_q;
      fail_vec_d  = fail_vec_q;
      pass_d      = pass_q;
      in_not_d    = in_not_q;
      in1_d       = in1_q;
      in2_d       = in2_q;

      // Expected responses for the vector currently on the gate inputs; case inequality
      // makes an X/Z from the gates count as a failure.
      exp_not  = ~idx_q[0];
      exp_nand = ~(idx_q[1] & idx_q[0]);
      mismatch = (out_not !== exp_not) || (out_nand !== exp_nand);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               idx_d       = 2'd0;
               pass_cnt_d  = '0;
               settle_d    = '0;
               err_count_d = '0;
               fail_vec_d  = 4'b0000;
               pass_d      = 1'b0;
               in_not_d    = 1'b0;
               in1_d       = 1'b0;
               in2_d       = 1'b0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d  = ST_IDLE;
               settle_d = '0;
               pass_d   = 1'b0;
               in_not_d = 1'b0;
               in1_d    = 1'b0;
               in2_d    = 1'b0;
            end else if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               if (mismatch) begin
                  if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                  fail_vec_d[idx_q] = 1'b1;
               end
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
               end else if (pass_cnt_q != PASS_LAST) begin
                  idx_d      = 2'd0;
                  pass_cnt_d = pass_cnt_q + 1'b1;
               end else begin
                  state_d = ST_DONE;
                  pass_d  = (err_count_d == '0);
               end
               in_not_d = (state_d == ST_RUN) ? idx_d[0] : 1'b0;
               in1_d    = (state_d == ST_RUN) ? idx_d[1] : 1'b0;
               in2_d    = (state_d == ST_RUN) ? idx_d[0] : 1'b0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         pass_cnt_q  <= '0;
         settle_q    <= '0;
         err_count_q <= '0;
         fail_vec_q  <= 4'b0000;
         pass_q      <= 1'b0;
         in_not_q    <= 1'b0;
         in1_q       <= 1'b0;
         in2_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pass_cnt_q  <= pass_cnt_d;
         settle_q    <= settle_d;
         err_count_q <= err_count_d;
         fail_vec_q  <= fail_vec_d;
         pass_q      <= pass_d;
         in_not_q    <= in_not_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign err_count = err_count_q;
   assign fail_vec  = fail_vec_q;
   assign in_not    = in_not_q;
   assign in1_nand  = in1_q;
   assign in2_nand  = in2_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: three instances (different PASSES/ERR_W) each
// wired to a small gate model whose fault mode is selected per test.
module tb_gate_test_sequencer;

   logic       clk;
   logic       reset_L;
   logic [2:0] start_v, abort_v;
   logic [2:0] o_not, o_nand, i_not, i1, i2, busy_v, done_v, pass_v;
   logic [3:0] err_a, err_b, fail_a, fail_b, fail_c;
   logic [1:0] err_c;
   logic [1:0] mode [3];   // 0 good, 1 nand stuck-1, 2 not stuck-0, 3 both inverted

   int n_vec = 0;
   int n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   gate_test_sequencer #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u_a (
      .clk(clk), .reset_L(reset_L), .start(start_v[0]), .abort(abort_v[0]),
      .out_not(o_not[0]), .out_nand(o_nand[0]), .in_not(i_not[0]), .in1_nand(i1[0]),
      .in2_nand(i2[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_count(err_a), .fail_vec(fail_a));

   gate_test_sequencer #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(4)) u_b (
      .clk(clk), .reset_L(reset_L), .start(start_v[1]), .abort(abort_v[1]),
      .out_not(o_not[1]), .out_nand(o_nand[1]), .in_not(i_not[1]), .in1_nand(i1[1]),
      .in2_nand(i2[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_count(err_b), .fail_vec(fail_b));

   gate_test_sequencer #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u_c (
      .clk(clk), .reset_L(reset_L), .start(start_v[2]), .abort(abort_v[2]),
      .out_not(o_not[2]), .out_nand(o_nand[2]), .in_not(i_not[2]), .in1_nand(i1[2]),
      .in2_nand(i2[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_count(err_c), .fail_vec(fail_c));

   for (genvar g = 0; g < 3; g++) begin : g_model
      assign o_not[g]  = (mode[g] == 2'd2) ? 1'b0 :
                         (mode[g] == 2'd3) ? i_not[g] : ~i_not[g];
      assign o_nand[g] = (mode[g] == 2'd1) ? 1'b1 :
                         (mode[g] == 2'd3) ? (i1[g] & i2[g]) : ~(i1[g] & i2[g]);
   end

   function automatic logic [3:0] obs_io(input int d);
      return {busy_v[d], i1[d], i2[d], i_not[d]};
   endfunction

   function automatic logic [3:0] obs_err(input int d);
      case (d)
         0:       return err_a;
         1:       return err_b;
         default: return {2'b00, err_c};
      endcase
   endfunction

   function automatic logic [3:0] obs_fail(input int d);
      case (d)
         0:       return fail_a;
         1:       return fail_b;
         default: return fail_c;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_idle(input string tag, input int d);
      check({tag, "_io"},   {4'h0, obs_io(d)}, 8'h00);
      check({tag, "_done"}, {7'd0, done_v[d]}, 8'h00);
   endtask

   // Full run from a negedge: {busy,in1,in2,in_not} each cycle, then the results.
   task automatic run_seq(input int d, input int passes, input int mid_k,
                          input logic [3:0] exp_err, input logic [3:0] exp_fail,
                          input logic exp_pass);
      logic [1:0] v;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      for (int k = 0; k < 8 * passes; k++) begin
         v = 2'((k / 2) % 4);
         check($sformatf("io_d%0d_k%0d", d, k), {4'h0, obs_io(d)}, {4'h0, 1'b1, v[1], v[0], v[0]});
         if (k == 0) begin
            check("cleared_err",  {4'h0, obs_err(d)},  8'h00);
            check("cleared_fail", {4'h0, obs_fail(d)}, 8'h00);
            check("cleared_done", {7'd0, done_v[d]},   8'h00);
         end
         start_v[d] = (k == mid_k);
         @(negedge clk);
      end
      start_v[d] = 1'b0;
      check($sformatf("end_io_d%0d", d), {4'h0, obs_io(d)}, 8'h00);
      check($sformatf("done_d%0d", d),   {7'd0, done_v[d]}, 8'h01);
      check($sformatf("pass_d%0d", d),   {7'd0, pass_v[d]}, {7'd0, exp_pass});
      check($sformatf("err_d%0d", d),    {4'h0, obs_err(d)},  {4'h0, exp_err});
      check($sformatf("fail_d%0d", d),   {4'h0, obs_fail(d)}, {4'h0, exp_fail});
   endtask

   task automatic run_abort(input int d, input int abort_k,
                            input logic [3:0] exp_err, input logic [3:0] exp_fail);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      for (int k = 0; k <= abort_k; k++) begin
         if (k == abort_k) abort_v[d] = 1'b1;
         @(negedge clk);
      end
      abort_v[d] = 1'b0;
      check($sformatf("abort%0d", abort_k), 8'h00, 8'h00 | {4'h0, obs_io(d)});
      check("abort_done", {7'd0, done_v[d]}, 8'h00);
      check("abort_pass", {7'd0, pass_v[d]}, 8'h00);
      check("abort_err",  {4'h0, obs_err(d)},  {4'h0, exp_err});
      check("abort_fail", {4'h0, obs_fail(d)}, {4'h0, exp_fail});
      @(negedge clk);
      check_idle("abort_stay", d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_L = 1'b0;
      start_v = 3'b111;
      abort_v = 3'b000;
      for (int d = 0; d < 3; d++) mode[d] = 2'd0;

      // Reset held with start asserted and the clock running
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check_idle($sformatf("rst_d%0d", d), d);
         check("rst_pass", {7'd0, pass_v[d]}, 8'h00);
         check("rst_err",  {4'h0, obs_err(d)},  8'h00);
         check("rst_fail", {4'h0, obs_fail(d)}, 8'h00);
      end
      start_v = 3'b000;
      reset_L = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle($sformatf("post_rst_d%0d", d), d);

      run_seq(0, 1, -1, 4'd0, 4'b0000, 1'b1);
      mode[0] = 2'd1;
      run_seq(0, 1, -1, 4'd1, 4'b1000, 1'b0);
      mode[0] = 2'd0;
      run_seq(0, 1, 3, 4'd0, 4'b0000, 1'b1);

      // Abort on the first sample edge drops that sample; abort in vector 1 keeps partials
      mode[0] = 2'd3;
      run_abort(0, 1, 4'd0, 4'b0000);
      run_abort(0, 2, 4'd1, 4'b0001);

      // Asynchronous reset during vector 2
      mode[0] = 2'd0;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("vec2_io", {4'h0, obs_io(0)}, 8'h0c);
      #1 reset_L = 1'b0;
      #1;
      check_idle("async_rst", 0);
      check("async_rst_err", {4'h0, obs_err(0)}, 8'h00);
      @(negedge clk);
      reset_L = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("after_async_rst", 0);
      run_seq(0, 1, -1, 4'd0, 4'b0000, 1'b1);

      mode[1] = 2'd2;
      run_seq(1, 2, -1, 4'd4, 4'b0101, 1'b0);
      mode[2] = 2'd3;
      run_seq(2, 2, -1, 4'd3, 4'b1111, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
